wr_burst_sched: RTL and testbench
=================================

WR_BURST_SCHED -- requirements
Module: wr_burst_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, beats per write burst (1..64).
REQ-002 SHALL have parameter ADDR_W, default 29, MIG app address width.
REQ-003 SHALL have parameter ADDR_STEP, default 8, app_addr increment per 512-bit beat.
REQ-004 SHALL have parameter BASE_ADDR, default 0, frame start address.
REQ-005 SHALL have parameter FRAME_BEATS, default 1024, beats per frame; a multiple of BURST_LEN.
REQ-006 SHALL have port ui_clk, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port wr_en_i, input, 1, level enable for burst scheduling.
REQ-009 SHALL have port fifo_rd_count, input, 7, write-data FIFO read-side occupancy.
REQ-010 SHALL have port fifo_dout, input, 512, FWFT write-data FIFO data.
REQ-011 SHALL have port fifo_mask, input, 64, FWFT FIFO byte mask (1 = masked).
REQ-012 SHALL have port data_req, output, 1, FIFO read strobe, one per accepted beat.
REQ-013 SHALL have port app_en, output, 1, MIG command valid.
REQ-014 SHALL have port app_cmd, output, 3, MIG command; constant 3'b000 (write).
REQ-015 SHALL have port app_addr, output, ADDR_W, MIG command address.
REQ-016 SHALL have port app_rdy, input, 1, MIG command ready.
REQ-017 SHALL have port app_wdf_wren, output, 1, MIG write-data valid.
REQ-018 SHALL have port app_wdf_data, output, 512, MIG write data; equals fifo_dout.
REQ-019 SHALL have port app_wdf_mask, output, 64, MIG write mask; equals fifo_mask.
REQ-020 SHALL have port app_wdf_end, output, 1, equals app_wdf_wren (one beat per command).
REQ-021 SHALL have port app_wdf_rdy, input, 1, MIG write-data ready.
REQ-022 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-023 SHALL have port burst_done, output, 1, one-cycle pulse at burst end.
REQ-024 SHALL have port frame_done, output, 1, one-cycle pulse at frame wrap.

Function
REQ-025 SHALL implement a registered FSM with states IDLE, WRITE, DONE.
REQ-026 SHALL leave IDLE for WRITE when wr_en_i=1 and fifo_rd_count>=BURST_LEN; else remain in IDLE.
REQ-027 SHALL drive app_en=app_wdf_wren=1 combinationally throughout WRITE, and 0 in all other states.
REQ-028 SHALL accept a beat in a cycle where state=WRITE, app_rdy=1 and app_wdf_rdy=1; data_req SHALL equal this term combinationally.
REQ-029 SHALL hold app_addr, app_wdf_data and app_wdf_mask stable while a beat is pending and unaccepted (either ready low).
REQ-030 SHALL, on each accepted beat, increment the beat counter and advance app_addr by ADDR_STEP.
REQ-031 SHALL go WRITE->DONE on the accepted beat that makes the burst count equal BURST_LEN, and clear the burst counter.
REQ-032 SHALL spend exactly one cycle in DONE, pulse burst_done there, then return to IDLE.
REQ-033 SHALL maintain a frame beat counter; when an accepted beat reaches FRAME_BEATS, the next app_addr SHALL be BASE_ADDR, the frame counter SHALL clear, and frame_done SHALL pulse together with that burst's burst_done.
REQ-034 SHALL ignore wr_en_i deassertion during WRITE; the burst SHALL complete and the FSM SHALL then stop in IDLE.
REQ-035 SHALL have a minimum burst-to-burst gap of 2 cycles (DONE, IDLE).
REQ-036 SHALL never assert data_req when state is not WRITE; FIFO underflow is precluded by the occupancy check in REQ-026.

Reset
REQ-037 SHALL, while rst_n=0 (asynchronous, at any time including mid-burst), force state=IDLE, app_addr=BASE_ADDR, both counters=0, and busy=burst_done=frame_done=0; combinational outputs SHALL follow, so app_en=app_wdf_wren=data_req=0.
REQ-038 SHALL resume from BASE_ADDR after reset release; partial-burst data left in the FIFO SHALL be the FIFO owner's concern.

Verification
REQ-039 SHALL pass this test: BURST_LEN=32, count=40, wr_en_i=1, both readies high -> 32 consecutive data_req, app_addr 0..248 step 8, burst_done on the following cycle.
REQ-040 SHALL pass this test: count=31 with wr_en_i=1 -> no app_en; count rising to 32 -> WRITE entered the next cycle.
REQ-041 SHALL pass this test: app_wdf_rdy low for 3 cycles at beat 5 -> app_addr and data held, no data_req, completion delayed by 3 cycles.
REQ-042 SHALL pass this test: FRAME_BEATS=64, two full bursts -> frame_done with the second burst_done, and next burst app_addr=BASE_ADDR.
REQ-043 SHALL pass this test: wr_en_i dropped at beat 10 -> all 32 beats issued, then IDLE with busy=0.
REQ-044 SHALL pass this test: rst_n asserted at beat 12 -> app_en=0 immediately (asynchronous), and next burst starts at BASE_ADDR.

Source files
------------

// File: rtl/wr_burst_sched.sv
// wr_burst_sched: schedules fixed-length MIG write bursts from an FWFT
// write-data FIFO. One 512-bit beat per command; the command and data
// channels are driven together and a beat is accepted only when both
// the MIG command and write-data interfaces are ready.
module wr_burst_sched #(
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned ADDR_STEP   = 8,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_BEATS = 1024
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [6:0]        fifo_rd_count,
  input  logic [511:0]      fifo_dout,
  input  logic [63:0]       fifo_mask,
  output logic              data_req,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic [511:0]      app_wdf_data,
  output logic [63:0]       app_wdf_mask,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              busy,
  output logic              burst_done,
  output logic              frame_done
);

  localparam int unsigned FRAME_W = $clog2(FRAME_BEATS + 1);

  localparam logic [6:0]         BURST_LEN_C  = 7'(BURST_LEN);
  localparam logic [6:0]         BURST_LAST_C = 7'(BURST_LEN - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST_C = FRAME_W'(FRAME_BEATS - 1);
  localparam logic [ADDR_W-1:0]  BASE_C       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  STEP_C       = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [6:0]         burst_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               accept;
  logic               burst_last;
  logic               frame_last;
  logic               burst_done_q;
  logic               frame_done_q;

  assign burst_last = (burst_cnt == BURST_LAST_C);
  assign frame_last = (frame_cnt == FRAME_LAST_C);

  // Data and mask pass straight through; the FWFT FIFO holds them until data_req.
  assign app_cmd      = '0;
  assign app_wdf_data = fifo_dout;
  assign app_wdf_mask = fifo_mask;
  assign burst_done   = burst_done_q;
  assign frame_done   = frame_done_q;

  // State register
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start only when a whole burst is already buffered
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (wr_en_i && (fifo_rd_count >= BURST_LEN_C)) state_next = WRITE;
      WRITE:   if (accept && burst_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: command/data valid for the whole WRITE state
  always_comb begin
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    accept       = 1'b0;
    data_req     = 1'b0;
    busy         = (state != IDLE);
    if (state == WRITE) begin
      app_en       = 1'b1;
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
      accept       = app_rdy && app_wdf_rdy;
      data_req     = app_rdy && app_wdf_rdy;
    end
  end

  // Beat/frame counters, address generation and completion pulses.
  // Both pulses are registered from the final accepted beat, so they
  // land in the single DONE cycle that follows it.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      app_addr     <= BASE_C;
      burst_cnt    <= '0;
      frame_cnt    <= '0;
      burst_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      burst_done_q <= accept && burst_last;
      frame_done_q <= accept && frame_last;
      if (accept) begin
        burst_cnt <= burst_last ? '0 : burst_cnt + 7'd1;
        if (frame_last) begin
          frame_cnt <= '0;
          app_addr  <= BASE_C;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
          app_addr  <= app_addr + STEP_C;
        end
      end
    end
  end

endmodule

// File: tb/tb_wr_burst_sched.sv
// tb_wr_burst_sched: randomized scenario bench for wr_burst_sched with a
// beat-position reference model (address = base + position-in-frame * step).
module tb_wr_burst_sched;

  localparam int BL   = 32;
  localparam int FB   = 64;
  localparam int STEP = 8;
  localparam int BASE = 0;
  localparam int AW   = 29;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [6:0]    fifo_rd_count;
  logic [511:0]  fifo_dout;
  logic [63:0]   fifo_mask;
  logic          data_req;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic [511:0]  app_wdf_data;
  logic [63:0]   app_wdf_mask;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic          busy;
  logic          burst_done;
  logic          frame_done;

  int total;
  int bad;
  int frame_pos;

  wr_burst_sched #(
    .BURST_LEN  (BL),
    .ADDR_W     (AW),
    .ADDR_STEP  (STEP),
    .BASE_ADDR  (BASE),
    .FRAME_BEATS(FB)
  ) dut (
    .ui_clk       (clk),
    .rst_n        (rst_n),
    .wr_en_i      (wr_en),
    .fifo_rd_count(fifo_rd_count),
    .fifo_dout    (fifo_dout),
    .fifo_mask    (fifo_mask),
    .data_req     (data_req),
    .app_en       (app_en),
    .app_cmd      (app_cmd),
    .app_addr     (app_addr),
    .app_rdy      (app_rdy),
    .app_wdf_wren (app_wdf_wren),
    .app_wdf_data (app_wdf_data),
    .app_wdf_mask (app_wdf_mask),
    .app_wdf_end  (app_wdf_end),
    .app_wdf_rdy  (app_wdf_rdy),
    .busy         (busy),
    .burst_done   (burst_done),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one burst starting from an IDLE cycle; mode 0 = readies high,
  // 1 = app_wdf_rdy low 3 cycles at beat 5, 2 = random readies,
  // 3 = wr_en dropped at beat 10. Ends at the following IDLE cycle.
  task automatic run_burst(input int mode, input logic [6:0] cnt,
                           output int cycles, output logic fd);
    int beats;
    int stall;
    logic r;
    logic w;
    logic [AW-1:0] exp_addr;
    wr_en = 1'b1;
    fifo_rd_count = cnt;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    #1;
    total++; if (app_en !== 1'b0) begin bad++; $display("FAIL pre_start_app_en got=%b want=0", app_en); end
    beats = 0;
    cycles = 0;
    stall = 0;
    fd = 1'b0;
    while (beats < BL && cycles < 400) begin
      @(negedge clk);
      r = 1'b1;
      w = 1'b1;
      if (mode == 1 && beats == 5 && stall < 3) begin w = 1'b0; stall++; end
      if (mode == 2) begin
        r = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 3) != 0);
      end
      if (mode == 3 && beats == 10) wr_en = 1'b0;
      app_rdy = r;
      app_wdf_rdy = w;
      for (int i = 0; i < 16; i++) fifo_dout[i*32 +: 32] = $urandom;
      fifo_mask = {$urandom, $urandom};
      #1;
      exp_addr = AW'(BASE + frame_pos * STEP);
      total++; if (app_en !== 1'b1) begin bad++; $display("FAIL write_app_en beat=%0d got=%b want=1", beats, app_en); end
      total++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1) begin bad++; $display("FAIL write_wdf_wren_end got=%b%b want=11", app_wdf_wren, app_wdf_end); end
      total++; if (app_cmd !== 3'b000) begin bad++; $display("FAIL app_cmd got=%b want=000", app_cmd); end
      total++; if (app_addr !== exp_addr) begin bad++; $display("FAIL app_addr beat=%0d got=%0h want=%0h", beats, app_addr, exp_addr); end
      total++; if (data_req !== (r & w)) begin bad++; $display("FAIL data_req beat=%0d got=%b want=%b", beats, data_req, r & w); end
      total++; if (app_wdf_data !== fifo_dout || app_wdf_mask !== fifo_mask) begin bad++; $display("FAIL wdf_passthrough beat=%0d got=%0h want=%0h", beats, app_wdf_mask, fifo_mask); end
      total++; if (busy !== 1'b1 || burst_done !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL write_flags got=%b%b%b want=100", busy, burst_done, frame_done); end
      if (r && w) begin
        beats++;
        frame_pos = (frame_pos + 1) % FB;
      end
      cycles++;
    end
    total++; if (beats != BL) begin bad++; $display("FAIL burst_timeout got=%0d want=%0d", beats, BL); end
    @(negedge clk);
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    #1;
    fd = frame_done;
    total++; if (app_en !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL done_app_en got=%b%b want=00", app_en, data_req); end
    total++; if (busy !== 1'b1 || burst_done !== 1'b1) begin bad++; $display("FAIL done_pulse got=%b%b want=11", busy, burst_done); end
    total++; if (frame_done !== (frame_pos == 0)) begin bad++; $display("FAIL done_frame got=%b want=%b", frame_done, frame_pos == 0); end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || burst_done !== 1'b0 || frame_done !== 1'b0 || app_en !== 1'b0) begin bad++; $display("FAIL idle_after got=%b%b%b%b want=0000", busy, burst_done, frame_done, app_en); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wr_en = 1'b1;
    fifo_rd_count = 7'd40;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    fifo_dout = '0;
    fifo_mask = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      total++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL reset_outputs got=%b%b%b want=000", app_en, app_wdf_wren, data_req); end
      total++; if (busy !== 1'b0 || burst_done !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", busy, burst_done, frame_done); end
      total++; if (app_addr !== AW'(BASE)) begin bad++; $display("FAIL reset_addr got=%0h want=%0h", app_addr, BASE); end
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    frame_pos = 0;
    #1;
  endtask

  task automatic test_basic;
    int cyc;
    logic fd;
    run_burst(0, 7'd40, cyc, fd);
    total++; if (cyc != BL) begin bad++; $display("FAIL basic_consecutive got=%0d want=%0d", cyc, BL); end
  endtask

  task automatic test_threshold;
    int cyc;
    logic fd;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      fifo_rd_count = 7'($urandom_range(0, BL - 1));
      @(negedge clk);
      #1;
      total++; if (app_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL below_threshold count=%0d got=%b%b want=00", fifo_rd_count, app_en, busy); end
    end
    run_burst(0, 7'(BL), cyc, fd);
    total++; if (cyc != BL) begin bad++; $display("FAIL threshold_burst got=%0d want=%0d", cyc, BL); end
  endtask

  task automatic test_stall;
    int cyc;
    logic fd;
    run_burst(1, 7'd40, cyc, fd);
    total++; if (cyc != BL + 3) begin bad++; $display("FAIL stall_delay got=%0d want=%0d", cyc, BL + 3); end
  endtask

  task automatic test_wr_en_drop;
    int cyc;
    logic fd;
    run_burst(3, 7'd40, cyc, fd);
    total++; if (cyc != BL) begin bad++; $display("FAIL drop_beats got=%0d want=%0d", cyc, BL); end
    fifo_rd_count = 7'd60;
    repeat (3) begin
      @(negedge clk);
      #1;
      total++; if (busy !== 1'b0 || app_en !== 1'b0) begin bad++; $display("FAIL drop_stays_idle got=%b%b want=00", busy, app_en); end
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic fd;
    logic [AW-1:0] exp_addr;
    wr_en = 1'b1;
    fifo_rd_count = 7'd40;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      exp_addr = AW'(BASE + frame_pos * STEP);
      total++; if (data_req !== 1'b1 || app_addr !== exp_addr) begin bad++; $display("FAIL pre_reset_beat got=%b/%0h want=1/%0h", data_req, app_addr, exp_addr); end
      frame_pos = (frame_pos + 1) % FB;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || data_req !== 1'b0) begin bad++; $display("FAIL async_reset_outputs got=%b%b%b want=000", app_en, app_wdf_wren, data_req); end
    total++; if (busy !== 1'b0 || app_addr !== AW'(BASE)) begin bad++; $display("FAIL async_reset_state got=%b/%0h want=0/%0h", busy, app_addr, BASE); end
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    frame_pos = 0;
    #1;
    run_burst(0, 7'd40, cyc, fd);
    total++; if (cyc != BL) begin bad++; $display("FAIL post_reset_burst got=%0d want=%0d", cyc, BL); end
  endtask

  task automatic test_frame;
    int cyc;
    logic fd;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    frame_pos = 0;
    run_burst(0, 7'd40, cyc, fd);
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL frame_first got=%b want=0", fd); end
    run_burst(2, 7'd64, cyc, fd);
    total++; if (fd !== 1'b1) begin bad++; $display("FAIL frame_second got=%b want=1", fd); end
    run_burst(0, 7'd40, cyc, fd);
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL frame_third got=%b want=0", fd); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic fd;
    for (int i = 0; i < 6; i++) begin
      run_burst(2, 7'($urandom_range(BL, 127)), cyc, fd);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    frame_pos = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    fifo_rd_count = '0;
    fifo_dout = '0;
    fifo_mask = '0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    test_reset();
    test_basic();
    test_threshold();
    test_stall();
    test_wr_en_drop();
    test_reset_mid();
    test_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
